pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Next-generation PC generator for the MIPS pipeline: owns the F-stage PC register and resolves D-stage branches and jumps.
- Handles ERET, exception entry and delay-slot (BD) tracking.
- Talks to a variable-latency instruction memory through a ready handshake.
- Extends the combinational next-PC logic with:
  - a wider branch set;
  - a pending-redirect latch, so a branch can resolve before its delay slot has been fetched.

Parameters:
- ADDR_W, 32, PC width; upper bits above ADDR_W read as zero.
- RESET_PC, 32'h0000_3000, PC after reset.
- EXC_VEC, 32'h0000_4180, exception handler entry.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  fetch address; always equals pc_q
- imem_ready  in  1  instruction for imem_addr is valid; memory holds it while the address is stable
- stall_d  in  1  D stage frozen; the fetch is not accepted and the D-stage op is not consumed
- f_valid  out  1  fetched word accepted into the F/D register this cycle (not squashed)
- f_pc  out  ADDR_W  PC of the word being fetched
- f_bd  out  1  word being fetched is a delay slot
- d_valid  in  1  D-stage instruction is valid
- d_op  in  4  jump op code (package encoding)
- d_pc4  in  ADDR_W  D-stage PC+4
- d_data1, d_data2  in  32  forwarded rs/rt values
- d_imm26  in  26  jump index
- d_imm32  in  32  sign-extended branch offset
- epc  in  ADDR_W  CP0 EPC
- exc_req  in  1  exception taken in M; flush and vector

Behaviour:
- Reset values:
  - pc_q = RESET_PC, state = SEQ, pend_q = 0.
  - f_valid = 0, f_bd = 0.
  - imem_addr = RESET_PC.
- accept = imem_ready & ~stall_d.
- f_valid = accept & ~squash, where squash = exc_req | (D-stage ERET consumed this cycle).
- Branch resolution is combinational, for every d_op:
  - BEQ/BNE: compare d_data1 with d_data2.
  - BLEZ/BGTZ/BLTZ/BGEZ: signed compare of d_data1 against 0.
  - Branch target = d_pc4 + (d_imm32 << 2).
  - J/JAL target = {d_pc4[31:28], d_imm26, 2'b00}.
  - JR/JALR target = d_data1.
  - ERET target = epc.
  - next = taken ? target : d_pc4 + 4.
- A D-stage op is consumed when d_valid & ~stall_d & d_op != NONE.
- FSM states:
  - SEQ: normal fetch. On accept, pc_q <= pc_q + 4.
  - SLOT: a branch or jump has resolved; its delay slot has not yet been accepted. pend_q holds the resolved next PC.
- Transitions, in priority order:
  1. exc_req:
     - pc_q <= EXC_VEC, state <= SEQ.
     - Any accept this cycle is squashed.
     - Overrides stall_d.
  2. ERET consumed:
     - pc_q <= epc, state <= SEQ, pend_q cleared.
     - The F-stage word is squashed. ERET has no delay slot.
  3. Branch/jump consumed (any of the ten branch/jump ops, taken or not):
     - With accept this cycle: pc_q <= next, state stays SEQ, f_bd = 1.
     - Without accept: pend_q <= next, state <= SLOT, pc_q is unchanged.
  4. State SLOT with accept: pc_q <= pend_q, state <= SEQ.
  5. SEQ with accept: pc_q <= pc_q + 4.
- f_bd = 1 when state == SLOT, or when a branch/jump is consumed this cycle.
- imem_addr does not change while imem_ready is low, except under rules 1 and 2; the memory aborts the old request.
- A branch/jump in D while state == SLOT is illegal (branch in a delay slot). It is ignored; the pending target wins.
- Reset asserted mid-fetch returns to the reset values immediately; any in-flight word is dropped.
- Adders wrap modulo 2^ADDR_W.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined, adds output f_adel. It is high when pc_q[1:0] != 0; this is registered alongside pc_q, so f_adel tracks the current fetch. f_valid still asserts, so the exception can flow with the word, and the F/D register substitutes a NOP.
- When undefined, the port is absent and pc_q[1:0] are ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - JUMP_* encodings: NONE 0, BEQ 1, BNE 2, JAL 3, JR 4, ERET 5, BLEZ 6, BGTZ 7, BLTZ 8, BGEZ 9, J 10, JALR 11;
  - the FSM state typedef (SEQ, SLOT);
  - default RESET_PC and EXC_VEC.
- One combinational sub-module, npc_resolve, computes taken, target and next.
- pc_gen holds the registers and FSM.

Test Plan:
- Reset, then imem_ready = 1 with no branches → f_pc sequence 0x3000, 0x3004, 0x3008; f_valid = 1 every cycle; f_bd = 0.
- BEQ at 0x3010 in D with d_data1 = d_data2 = 5, d_imm32 = 3, slot accepted the same cycle → f_bd = 1 at 0x3014; next f_pc = 0x3020.
- BNE at 0x3010, not taken, slot imem_ready delayed 3 cycles → state SLOT and f_pc held at 0x3014 for 3 cycles; on accept f_bd = 1; then f_pc = 0x3018.
- JR with d_data1 = 0x3400 while stall_d = 1 for 2 cycles → no redirect while stalled; consumed on release; f_pc reaches 0x3400 after the slot.
- ERET in D with epc = 0x3100 → f_valid = 0 that cycle (squash); next f_pc = 0x3100; f_bd = 0.
- exc_req while state == SLOT and stall_d = 1 → next f_pc = 0x4180, state SEQ, pend_q discarded, f_valid = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg: jump op encodings, PC FSM state type and PC constants        |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam logic [3:0] JUMP_NONE = 4'd0;
   localparam logic [3:0] JUMP_BEQ  = 4'd1;
   localparam logic [3:0] JUMP_BNE  = 4'd2;
   localparam logic [3:0] JUMP_JAL  = 4'd3;
   localparam logic [3:0] JUMP_JR   = 4'd4;
   localparam logic [3:0] JUMP_ERET = 4'd5;
   localparam logic [3:0] JUMP_BLEZ = 4'd6;
   localparam logic [3:0] JUMP_BGTZ = 4'd7;
   localparam logic [3:0] JUMP_BLTZ = 4'd8;
   localparam logic [3:0] JUMP_BGEZ = 4'd9;
   localparam logic [3:0] JUMP_J    = 4'd10;
   localparam logic [3:0] JUMP_JALR = 4'd11;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

   typedef enum logic [0:0] {
      SEQ  = 1'b0,
      SLOT = 1'b1
   } pc_state_e;

   // True for every op that owns a delay slot (all control ops except ERET)
   function automatic logic is_bj(input logic [3:0] op);
      case (op)
         JUMP_BEQ, JUMP_BNE, JUMP_JAL, JUMP_JR, JUMP_BLEZ,
         JUMP_BGTZ, JUMP_BLTZ, JUMP_BGEZ, JUMP_J, JUMP_JALR: is_bj = 1'b1;
         default:                                             is_bj = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/npc_resolve.sv
// +----------------------------------------------------------------------+
// | npc_resolve: combinational D-stage branch/jump resolution             |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module npc_resolve
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] pc4,
   input  logic [31:0]       data1,
   input  logic [31:0]       data2,
   input  logic [25:0]       imm26,
   input  logic [31:0]       imm32,
   input  logic [ADDR_W-1:0] epc,
   output logic              taken,
   output logic [ADDR_W-1:0] target,
   output logic [ADDR_W-1:0] next
);

   logic [31:0] pc4_w;
   logic [31:0] seq_w;
   logic [31:0] br_tgt_w;
   logic [31:0] tgt_w;

   // All arithmetic in a 32-bit domain, truncated back to ADDR_W
   assign pc4_w    = 32'(pc4);
   assign seq_w    = pc4_w + 32'd4;
   assign br_tgt_w = pc4_w + (imm32 << 2);

   always_comb begin
      taken = 1'b0;
      tgt_w = br_tgt_w;
      case (op)
         JUMP_BEQ:  taken = (data1 == data2);
         JUMP_BNE:  taken = (data1 != data2);
         JUMP_BLEZ: taken = ($signed(data1) <= 32'sd0);
         JUMP_BGTZ: taken = ($signed(data1) >  32'sd0);
         JUMP_BLTZ: taken = ($signed(data1) <  32'sd0);
         JUMP_BGEZ: taken = ($signed(data1) >= 32'sd0);
         JUMP_J, JUMP_JAL: begin
            taken = 1'b1;
            tgt_w = {pc4_w[31:28], imm26, 2'b00};
         end
         JUMP_JR, JUMP_JALR: begin
            taken = 1'b1;
            tgt_w = data1;
         end
         JUMP_ERET: begin
            taken = 1'b1;
            tgt_w = 32'(epc);
         end
         default: begin
            taken = 1'b0;
            tgt_w = br_tgt_w;
         end
      endcase
   end

   assign target = ADDR_W'(tgt_w);
   assign next   = taken ? ADDR_W'(tgt_w) : ADDR_W'(seq_w);

endmodule

`default_nettype wire

// File: rtl/pc_gen.sv
// +----------------------------------------------------------------------+
// | pc_gen: F-stage PC register, delay-slot FSM, ERET/exception redirect  |
// | Optional: PC_ALIGN_CHECK_EN adds the f_adel misaligned-fetch output   |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module pc_gen
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(DEF_EXC_VEC)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              stall_d,
   output logic              f_valid,
   output logic [ADDR_W-1:0] f_pc,
   output logic              f_bd,
   input  logic              d_valid,
   input  logic [3:0]        d_op,
   input  logic [ADDR_W-1:0] d_pc4,
   input  logic [31:0]       d_data1,
   input  logic [31:0]       d_data2,
   input  logic [25:0]       d_imm26,
   input  logic [31:0]       d_imm32,
   input  logic [ADDR_W-1:0] epc,
   input  logic              exc_req
`ifdef PC_ALIGN_CHECK_EN
   ,
   output logic              f_adel
`endif
);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_q, pend_d;

   logic              accept;
   logic              consume;
   logic              eret_c;
   logic              bj_c;
   logic              squash;
   logic              res_taken;
   logic [ADDR_W-1:0] res_target;
   logic [ADDR_W-1:0] res_next;
   logic              unused_res;

   npc_resolve #(
      .ADDR_W (ADDR_W)
   ) u_npc_resolve (
      .op     (d_op),
      .pc4    (d_pc4),
      .data1  (d_data1),
      .data2  (d_data2),
      .imm26  (d_imm26),
      .imm32  (d_imm32),
      .epc    (epc),
      .taken  (res_taken),
      .target (res_target),
      .next   (res_next)
   );

   assign unused_res = &{1'b0, res_taken, res_target};

   assign accept  = imem_ready & ~stall_d;
   assign consume = d_valid & ~stall_d & (d_op != JUMP_NONE);
   assign eret_c  = consume & (d_op == JUMP_ERET);
   // A branch sitting in a delay slot is ignored; the pending target wins
   assign bj_c    = consume & is_bj(d_op) & (state_q == SEQ);
   assign squash  = exc_req | eret_c;

   assign imem_addr = pc_q;
   assign f_pc      = pc_q;
   assign f_valid   = accept & ~squash;
   assign f_bd      = (state_q == SLOT) | bj_c;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      if (exc_req) begin
         pc_d    = EXC_VEC;
         state_d = SEQ;
         pend_d  = '0;
      end else if (eret_c) begin
         pc_d    = epc;
         state_d = SEQ;
         pend_d  = '0;
      end else if (bj_c) begin
         if (accept) begin
            pc_d = res_next;
         end else begin
            pend_d  = res_next;
            state_d = SLOT;
         end
      end else if (accept) begin
         if (state_q == SLOT) begin
            pc_d    = pend_q;
            state_d = SEQ;
         end else begin
            pc_d = pc_q + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SEQ;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic adel_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         adel_q <= |RESET_PC[1:0];
      end else begin
         adel_q <= |pc_d[1:0];
      end
   end

   assign f_adel = adel_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// +----------------------------------------------------------------------+
// | tb_pc_gen: directed self-checking bench for pc_gen                    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pc_gen;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        stall_d = 1'b0;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        f_bd;
   logic        d_valid = 1'b0;
   logic [3:0]  d_op = JUMP_NONE;
   logic [31:0] d_pc4 = '0;
   logic [31:0] d_data1 = '0;
   logic [31:0] d_data2 = '0;
   logic [25:0] d_imm26 = '0;
   logic [31:0] d_imm32 = '0;
   logic [31:0] epc = '0;
   logic        exc_req = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
   logic        f_adel;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk        (clk),
      .reset      (reset),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .stall_d    (stall_d),
      .f_valid    (f_valid),
      .f_pc       (f_pc),
      .f_bd       (f_bd),
      .d_valid    (d_valid),
      .d_op       (d_op),
      .d_pc4      (d_pc4),
      .d_data1    (d_data1),
      .d_data2    (d_data2),
      .d_imm26    (d_imm26),
      .d_imm32    (d_imm32),
      .epc        (epc),
      .exc_req    (exc_req)
`ifdef PC_ALIGN_CHECK_EN
      ,
      .f_adel     (f_adel)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Apply one cycle of inputs at the falling edge; outputs settle 1ns later
   task automatic setd(input logic rdy, input logic stl, input logic [3:0] op,
                       input logic [31:0] pc4, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [25:0] i26, input logic [31:0] i32, input logic ex);
      @(negedge clk);
      imem_ready = rdy;
      stall_d    = stl;
      d_valid    = (op != JUMP_NONE);
      d_op       = op;
      d_pc4      = pc4;
      d_data1    = d1;
      d_data2    = d2;
      d_imm26    = i26;
      d_imm32    = i32;
      exc_req    = ex;
      #1;
   endtask

   task automatic idle(input logic rdy);
      setd(rdy, 1'b0, JUMP_NONE, '0, '0, '0, '0, '0, 1'b0);
   endtask

   // Reset is dropped mid-cycle; the PC must return at once
   task automatic do_reset();
      @(negedge clk);
      #2;
      imem_ready = 1'b0;
      d_valid    = 1'b0;
      d_op       = JUMP_NONE;
      exc_req    = 1'b0;
      stall_d    = 1'b0;
      reset      = 1'b0;
      #1;
      check("rst_addr", imem_addr, 32'h3000);
      check("rst_fvalid", {31'b0, f_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Five sequential accepts from reset leave pc_q = 0x3014
   task automatic walk_to_3014();
      for (int i = 0; i < 5; i++) idle(1'b1);
   endtask

   initial begin
      // Reset state and plain sequential fetch
      do_reset();
      check("rst_bd", {31'b0, f_bd}, 32'd0);
      idle(1'b1);
      check("seq0_pc", f_pc, 32'h3000);
      check("seq0_valid", {31'b0, f_valid}, 32'd1);
      check("seq0_bd", {31'b0, f_bd}, 32'd0);
      idle(1'b1);
      check("seq1_pc", f_pc, 32'h3004);
      idle(1'b1);
      check("seq2_pc", f_pc, 32'h3008);
      check("seq2_valid", {31'b0, f_valid}, 32'd1);
      idle(1'b1);
      idle(1'b1);
      // BEQ taken, slot accepted in the same cycle: 0x3014 + 3*4 = 0x3020
      setd(1'b1, 1'b0, JUMP_BEQ, 32'h3014, 32'd5, 32'd5, '0, 32'd3, 1'b0);
      check("beq_slot_pc", f_pc, 32'h3014);
      check("beq_slot_bd", {31'b0, f_bd}, 32'd1);
      check("beq_slot_valid", {31'b0, f_valid}, 32'd1);
      idle(1'b1);
      check("beq_tgt_pc", f_pc, 32'h3020);
      check("beq_tgt_bd", {31'b0, f_bd}, 32'd0);

      // BNE not taken, delay slot waits three cycles for memory
      do_reset();
      walk_to_3014();
      setd(1'b0, 1'b0, JUMP_BNE, 32'h3014, 32'd7, 32'd7, '0, 32'd3, 1'b0);
      check("bne_w0_pc", f_pc, 32'h3014);
      check("bne_w0_bd", {31'b0, f_bd}, 32'd1);
      check("bne_w0_valid", {31'b0, f_valid}, 32'd0);
      for (int i = 1; i < 3; i++) begin
         idle(1'b0);
         check("bne_wait_pc", f_pc, 32'h3014);
         check("bne_wait_bd", {31'b0, f_bd}, 32'd1);
      end
      idle(1'b1);
      check("bne_acc_pc", f_pc, 32'h3014);
      check("bne_acc_bd", {31'b0, f_bd}, 32'd1);
      check("bne_acc_valid", {31'b0, f_valid}, 32'd1);
      idle(1'b1);
      check("bne_next_pc", f_pc, 32'h3018);
      check("bne_next_bd", {31'b0, f_bd}, 32'd0);

      // JR held by a two-cycle stall
      do_reset();
      walk_to_3014();
      for (int i = 0; i < 2; i++) begin
         setd(1'b1, 1'b1, JUMP_JR, 32'h3014, 32'h3400, '0, '0, '0, 1'b0);
         check("jr_stall_pc", f_pc, 32'h3014);
         check("jr_stall_valid", {31'b0, f_valid}, 32'd0);
         check("jr_stall_bd", {31'b0, f_bd}, 32'd0);
      end
      setd(1'b1, 1'b0, JUMP_JR, 32'h3014, 32'h3400, '0, '0, '0, 1'b0);
      check("jr_go_bd", {31'b0, f_bd}, 32'd1);
      check("jr_go_valid", {31'b0, f_valid}, 32'd1);
      idle(1'b1);
      check("jr_tgt_pc", f_pc, 32'h3400);

      // ERET squashes the fetch and returns to EPC
      do_reset();
      idle(1'b1);
      idle(1'b1);
      epc = 32'h3100;
      setd(1'b1, 1'b0, JUMP_ERET, 32'h3008, '0, '0, '0, '0, 1'b0);
      check("eret_valid", {31'b0, f_valid}, 32'd0);
      check("eret_bd", {31'b0, f_bd}, 32'd0);
      idle(1'b1);
      check("eret_pc", f_pc, 32'h3100);
      check("eret_after_valid", {31'b0, f_valid}, 32'd1);

      // Exception while in SLOT under stall discards the pending target
      do_reset();
      walk_to_3014();
      setd(1'b0, 1'b0, JUMP_BEQ, 32'h3014, 32'd1, 32'd1, '0, 32'd3, 1'b0);
      setd(1'b1, 1'b1, JUMP_NONE, '0, '0, '0, '0, '0, 1'b1);
      check("exc_valid", {31'b0, f_valid}, 32'd0);
      idle(1'b1);
      check("exc_pc", f_pc, 32'h4180);
      check("exc_bd", {31'b0, f_bd}, 32'd0);
      idle(1'b1);
      check("exc_seq_pc", f_pc, 32'h4184);

      // Branch in a delay slot is ignored
      do_reset();
      walk_to_3014();
      setd(1'b0, 1'b0, JUMP_BEQ, 32'h3014, 32'd2, 32'd2, '0, 32'd3, 1'b0);
      setd(1'b1, 1'b0, JUMP_J, 32'h3018, '0, '0, 26'h0000E00, '0, 1'b0);
      check("bis_bd", {31'b0, f_bd}, 32'd1);
      check("bis_valid", {31'b0, f_valid}, 32'd1);
      idle(1'b1);
      check("bis_pc", f_pc, 32'h3020);

      // Signed compares and J target
      do_reset();
      walk_to_3014();
      setd(1'b1, 1'b0, JUMP_BLTZ, 32'h3014, 32'hFFFF_FFFF, '0, '0, 32'hFFFF_FFFE, 1'b0);
      idle(1'b1);
      check("bltz_pc", f_pc, 32'h300C);
      setd(1'b1, 1'b0, JUMP_BGTZ, 32'h3010, 32'h8000_0000, '0, '0, 32'd8, 1'b0);
      check("bgtz_bd", {31'b0, f_bd}, 32'd1);
      idle(1'b1);
      check("bgtz_nt_pc", f_pc, 32'h3014);
      setd(1'b1, 1'b0, JUMP_J, 32'h3018, '0, '0, 26'h0000E00, '0, 1'b0);
      idle(1'b1);
      check("j_pc", f_pc, 32'h3800);

      // Mid-fetch reset drops everything
      idle(1'b0);
      do_reset();
      check("rst2_bd", {31'b0, f_bd}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
